// File: rtl/hit_resolver.sv
// ============================================================================
// Module  : hit_resolver
// Brief   : Turns per-player hit-landed levels into one hit event per attack,
//           applies damage/hitstun on frame ticks and sequences KO/restart.
//           Optional macro SIMUL_HIT_TRADE_EN: simultaneous hits trade.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hit_resolver #(
  parameter int         MAX_HEALTH     = 3,
  parameter int         DAMAGE         = 1,
  parameter int         HEALTH_W       = 4,
  parameter int         HITSTUN_FRAMES = 15,
  parameter int         KO_HOLD_FRAMES = 120,
  parameter logic [2:0] ATTACK_STATE   = 3'b010
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                hit1_lands,
  input  logic                hit2_lands,
  input  logic [2:0]          char1_state,
  input  logic [2:0]          char2_state,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic                p1_stun,
  output logic                p2_stun,
  output logic                p1_hit_pulse,
  output logic                p2_hit_pulse,
  output logic                clash_pulse,
  output logic                round_over,
  output logic [1:0]          winner,
  output logic [3:0]          p1_wins,
  output logic [3:0]          p2_wins
);

  localparam int STUN_W = $clog2(HITSTUN_FRAMES + 1);
  localparam int KO_W   = $clog2(KO_HOLD_FRAMES + 1);

  localparam logic [HEALTH_W-1:0] C_MAX_HEALTH = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] C_DAMAGE     = HEALTH_W'(DAMAGE);
  localparam logic [STUN_W-1:0]   C_HITSTUN    = STUN_W'(HITSTUN_FRAMES);
  localparam logic [KO_W-1:0]     C_KO_HOLD    = KO_W'(KO_HOLD_FRAMES);

  typedef enum logic [0:0] {
    FIGHT = 1'b0,
    KO    = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                hit1_used_q, hit1_used_d;
  logic                hit2_used_q, hit2_used_d;
  logic [HEALTH_W-1:0] p1_health_q, p1_health_d;
  logic [HEALTH_W-1:0] p2_health_q, p2_health_d;
  logic [STUN_W-1:0]   stun1_q, stun1_d;
  logic [STUN_W-1:0]   stun2_q, stun2_d;
  logic [KO_W-1:0]     ko_cnt_q, ko_cnt_d;
  logic                p1_hit_pulse_q, p1_hit_pulse_d;
  logic                p2_hit_pulse_q, p2_hit_pulse_d;
  logic                clash_q, clash_d;
  logic [1:0]          winner_q, winner_d;
  logic [3:0]          p1_wins_q, p1_wins_d;
  logic [3:0]          p2_wins_q, p2_wins_d;

  logic                w_fight;
  logic                w_p1_stun;
  logic                w_p2_stun;
  logic                w_p1_valid;
  logic                w_p2_valid;
  logic                w_apply1;
  logic                w_apply2;
  logic                w_clash;
  logic [HEALTH_W-1:0] w_p1_health_post;
  logic [HEALTH_W-1:0] w_p2_health_post;

  function automatic logic [HEALTH_W-1:0] sub_damage(input logic [HEALTH_W-1:0] h);
    if (h > C_DAMAGE) return h - C_DAMAGE;
    else              return '0;
  endfunction

  assign w_fight    = (state_q == FIGHT);
  assign w_p1_stun  = (stun1_q != '0);
  assign w_p2_stun  = (stun2_q != '0);
  assign w_p1_valid = w_fight & frame_tick & hit1_lands & ~hit1_used_q & ~w_p1_stun & ~w_p2_stun;
  assign w_p2_valid = w_fight & frame_tick & hit2_lands & ~hit2_used_q & ~w_p1_stun & ~w_p2_stun;

`ifdef SIMUL_HIT_TRADE_EN
  assign w_apply1 = w_p1_valid;
  assign w_apply2 = w_p2_valid;
  assign w_clash  = 1'b0;
`else
  // Simultaneous valid hits cancel each other but still consume both attacks
  assign w_apply1 = w_p1_valid & ~w_p2_valid;
  assign w_apply2 = w_p2_valid & ~w_p1_valid;
  assign w_clash  = w_p1_valid & w_p2_valid;
`endif

  // w_apply1 means P1 damaged P2, so it drives P2's health and vice versa
  assign w_p1_health_post = w_apply2 ? sub_damage(p1_health_q) : p1_health_q;
  assign w_p2_health_post = w_apply1 ? sub_damage(p2_health_q) : p2_health_q;

  always_comb begin
    state_d        = state_q;
    p1_health_d    = p1_health_q;
    p2_health_d    = p2_health_q;
    stun1_d        = stun1_q;
    stun2_d        = stun2_q;
    ko_cnt_d       = ko_cnt_q;
    p1_hit_pulse_d = 1'b0;
    p2_hit_pulse_d = 1'b0;
    clash_d        = 1'b0;
    winner_d       = winner_q;
    p1_wins_d      = p1_wins_q;
    p2_wins_d      = p2_wins_q;
    hit1_used_d    = (char1_state != ATTACK_STATE) ? 1'b0 : (hit1_used_q | w_p1_valid);
    hit2_used_d    = (char2_state != ATTACK_STATE) ? 1'b0 : (hit2_used_q | w_p2_valid);

    case (state_q)
      FIGHT: begin
        p1_health_d = w_p1_health_post;
        p2_health_d = w_p2_health_post;
        clash_d     = w_clash;

        if (w_apply2) begin
          stun1_d        = C_HITSTUN;
          p1_hit_pulse_d = 1'b1;
        end else if (frame_tick && w_p1_stun) begin
          stun1_d = stun1_q - STUN_W'(1);
        end

        if (w_apply1) begin
          stun2_d        = C_HITSTUN;
          p2_hit_pulse_d = 1'b1;
        end else if (frame_tick && w_p2_stun) begin
          stun2_d = stun2_q - STUN_W'(1);
        end

        if ((w_apply1 || w_apply2) &&
            (w_p1_health_post == '0 || w_p2_health_post == '0)) begin
          state_d  = KO;
          ko_cnt_d = C_KO_HOLD;
          winner_d = {w_p1_health_post == '0, w_p2_health_post == '0};
          if (w_p2_health_post == '0 && w_p1_health_post != '0 && p1_wins_q != 4'hF)
            p1_wins_d = p1_wins_q + 4'd1;
          if (w_p1_health_post == '0 && w_p2_health_post != '0 && p2_wins_q != 4'hF)
            p2_wins_d = p2_wins_q + 4'd1;
        end
      end

      KO: begin
        if (frame_tick) begin
          if (ko_cnt_q <= KO_W'(1)) begin
            state_d     = FIGHT;
            ko_cnt_d    = '0;
            p1_health_d = C_MAX_HEALTH;
            p2_health_d = C_MAX_HEALTH;
            stun1_d     = '0;
            stun2_d     = '0;
            hit1_used_d = 1'b0;
            hit2_used_d = 1'b0;
            winner_d    = 2'b00;
          end else begin
            ko_cnt_d = ko_cnt_q - KO_W'(1);
          end
        end
      end

      default: state_d = FIGHT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= FIGHT;
      hit1_used_q    <= 1'b0;
      hit2_used_q    <= 1'b0;
      p1_health_q    <= C_MAX_HEALTH;
      p2_health_q    <= C_MAX_HEALTH;
      stun1_q        <= '0;
      stun2_q        <= '0;
      ko_cnt_q       <= '0;
      p1_hit_pulse_q <= 1'b0;
      p2_hit_pulse_q <= 1'b0;
      clash_q        <= 1'b0;
      winner_q       <= 2'b00;
      p1_wins_q      <= 4'd0;
      p2_wins_q      <= 4'd0;
    end else begin
      state_q        <= state_d;
      hit1_used_q    <= hit1_used_d;
      hit2_used_q    <= hit2_used_d;
      p1_health_q    <= p1_health_d;
      p2_health_q    <= p2_health_d;
      stun1_q        <= stun1_d;
      stun2_q        <= stun2_d;
      ko_cnt_q       <= ko_cnt_d;
      p1_hit_pulse_q <= p1_hit_pulse_d;
      p2_hit_pulse_q <= p2_hit_pulse_d;
      clash_q        <= clash_d;
      winner_q       <= winner_d;
      p1_wins_q      <= p1_wins_d;
      p2_wins_q      <= p2_wins_d;
    end
  end

  assign p1_health    = p1_health_q;
  assign p2_health    = p2_health_q;
  assign p1_stun      = w_p1_stun;
  assign p2_stun      = w_p2_stun;
  assign p1_hit_pulse = p1_hit_pulse_q;
  assign p2_hit_pulse = p2_hit_pulse_q;
  assign clash_pulse  = clash_q;
  assign round_over   = (state_q == KO);
  assign winner       = winner_q;
  assign p1_wins      = p1_wins_q;
  assign p2_wins      = p2_wins_q;

endmodule

`default_nettype wire

// File: tb/tb_hit_resolver.sv
// ============================================================================
// Module  : tb_hit_resolver
// Brief   : Directed scoreboard bench for hit_resolver (both trade builds).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hit_resolver;

  localparam logic [2:0] ATK  = 3'b010;
  localparam logic [2:0] IDLE = 3'b000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       hit1_lands = 1'b0;
  logic       hit2_lands = 1'b0;
  logic [2:0] char1_state = IDLE;
  logic [2:0] char2_state = IDLE;
  logic [3:0] p1_health, p2_health, p1_wins, p2_wins;
  logic       p1_stun, p2_stun, p1_hit_pulse, p2_hit_pulse, clash_pulse, round_over;
  logic [1:0] winner;

  hit_resolver dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .hit1_lands   (hit1_lands),
    .hit2_lands   (hit2_lands),
    .char1_state  (char1_state),
    .char2_state  (char2_state),
    .p1_health    (p1_health),
    .p2_health    (p2_health),
    .p1_stun      (p1_stun),
    .p2_stun      (p2_stun),
    .p1_hit_pulse (p1_hit_pulse),
    .p2_hit_pulse (p2_hit_pulse),
    .clash_pulse  (clash_pulse),
    .round_over   (round_over),
    .winner       (winner),
    .p1_wins      (p1_wins),
    .p2_wins      (p2_wins)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] h1, h2, w1, w2;
    logic [1:0] win;
    logic       s1, s2, p1, p2, cl, ro;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  string cur_tag = "reset";
  int    n_total = 0;
  int    n_pass  = 0;
  int    n_fail  = 0;

  // Expected post-edge values, maintained by the directed steps below
  logic [3:0] e_h1 = 4'd3, e_h2 = 4'd3, e_w1 = 4'd0, e_w2 = 4'd0;
  logic [1:0] e_win = 2'b00;
  logic       e_s1 = 0, e_s2 = 0, e_p1 = 0, e_p2 = 0, e_cl = 0, e_ro = 0;

  task automatic chk(input string tag, input string field, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic step(input logic tick);
    exp_t  e;
    string t;
    sb_q.push_back('{h1: e_h1, h2: e_h2, w1: e_w1, w2: e_w2, win: e_win,
                     s1: e_s1, s2: e_s2, p1: e_p1, p2: e_p2, cl: e_cl, ro: e_ro});
    tag_q.push_back(cur_tag);
    frame_tick = tick;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    if (sb_q.size() == 0) begin
      n_total++;
      n_fail++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      chk(t, "p1_health",    {4'd0, p1_health},    {4'd0, e.h1});
      chk(t, "p2_health",    {4'd0, p2_health},    {4'd0, e.h2});
      chk(t, "p1_stun",      {7'd0, p1_stun},      {7'd0, e.s1});
      chk(t, "p2_stun",      {7'd0, p2_stun},      {7'd0, e.s2});
      chk(t, "p1_hit_pulse", {7'd0, p1_hit_pulse}, {7'd0, e.p1});
      chk(t, "p2_hit_pulse", {7'd0, p2_hit_pulse}, {7'd0, e.p2});
      chk(t, "clash_pulse",  {7'd0, clash_pulse},  {7'd0, e.cl});
      chk(t, "round_over",   {7'd0, round_over},   {7'd0, e.ro});
      chk(t, "winner",       {6'd0, winner},       {6'd0, e.win});
      chk(t, "p1_wins",      {4'd0, p1_wins},      {4'd0, e.w1});
      chk(t, "p2_wins",      {4'd0, p2_wins},      {4'd0, e.w2});
    end
  endtask

  // One game frame: a tick cycle, then a quiet cycle where pulses must be gone
  task automatic frame();
    step(1'b1);
    e_p1 = 1'b0;
    e_p2 = 1'b0;
    e_cl = 1'b0;
    step(1'b0);
  endtask

  task automatic wait_stun();
    cur_tag = "stun_hold";
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) begin
        e_s1 = 1'b0;
        e_s2 = 1'b0;
      end
      frame();
    end
  endtask

  // Drop both attacks for one clk (clears hit_used), then re-raise the chosen ones
  task automatic rearm(input logic a1, input logic a2);
    char1_state = IDLE;
    char2_state = IDLE;
    hit1_lands  = 1'b0;
    hit2_lands  = 1'b0;
    cur_tag = "rearm";
    step(1'b0);
    char1_state = a1 ? ATK : IDLE;
    char2_state = a2 ? ATK : IDLE;
    hit1_lands  = a1;
    hit2_lands  = a2;
    step(1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
    step(1'b0);

    // First hit: P1 attacks P2, one hit only while ATTACK is held
    char1_state = ATK;
    hit1_lands  = 1'b1;
    cur_tag = "first_hit";
    e_h2 = 4'd2; e_s2 = 1'b1; e_p2 = 1'b1;
    frame();
    wait_stun();
    cur_tag = "held_attack_no_rehit";
    frame();
    frame();

    // Re-raised attack; overlap between ticks must be ignored
    rearm(1'b1, 1'b0);
    cur_tag = "between_ticks";
    step(1'b0);
    step(1'b0);
    cur_tag = "second_hit";
    e_h2 = 4'd1; e_s2 = 1'b1; e_p2 = 1'b1;
    frame();
    wait_stun();

    // Killing blow: KO on the same edge as the health update
    rearm(1'b1, 1'b0);
    cur_tag = "ko_hit";
    e_h2 = 4'd0; e_s2 = 1'b1; e_p2 = 1'b1;
    e_ro = 1'b1; e_win = 2'b01; e_w1 = 4'd1;
    frame();
    char1_state = IDLE;
    hit1_lands  = 1'b0;
    char2_state = ATK;
    hit2_lands  = 1'b1;
    cur_tag = "ko_hold";
    for (int i = 1; i <= 120; i++) begin
      if (i == 6) begin
        char2_state = IDLE;
        hit2_lands  = 1'b0;
      end
      if (i == 120) begin
        cur_tag = "restart";
        e_ro = 1'b0; e_win = 2'b00;
        e_h1 = 4'd3; e_h2 = 4'd3; e_s2 = 1'b0;
      end
      frame();
    end

    // Simultaneous valid hits
    rearm(1'b1, 1'b1);
    cur_tag = "simultaneous";
`ifdef SIMUL_HIT_TRADE_EN
    e_h1 = 4'd2; e_h2 = 4'd2; e_s1 = 1'b1; e_s2 = 1'b1; e_p1 = 1'b1; e_p2 = 1'b1;
    frame();
    wait_stun();
`else
    e_cl = 1'b1;
    frame();
`endif
    cur_tag = "after_simul_consumed";
    frame();

    // Single P2 hit on P1
    rearm(1'b0, 1'b1);
    cur_tag = "p2_hit";
    e_h1 = e_h1 - 4'd1; e_s1 = 1'b1; e_p1 = 1'b1;
    frame();
    wait_stun();

`ifdef SIMUL_HIT_TRADE_EN
    rearm(1'b1, 1'b0);
    cur_tag = "p1_hit_to_one";
    e_h2 = 4'd1; e_s2 = 1'b1; e_p2 = 1'b1;
    frame();
    wait_stun();
    rearm(1'b1, 1'b1);
    cur_tag = "double_ko";
    e_h1 = 4'd0; e_h2 = 4'd0; e_s1 = 1'b1; e_s2 = 1'b1; e_p1 = 1'b1; e_p2 = 1'b1;
    e_ro = 1'b1; e_win = 2'b11;
    frame();
`else
    rearm(1'b0, 1'b1);
    cur_tag = "p2_hit_to_one";
    e_h1 = 4'd1; e_s1 = 1'b1; e_p1 = 1'b1;
    frame();
    wait_stun();
    rearm(1'b0, 1'b1);
    cur_tag = "p2_ko";
    e_h1 = 4'd0; e_s1 = 1'b1; e_p1 = 1'b1;
    e_ro = 1'b1; e_win = 2'b10; e_w2 = 4'd1;
    frame();
`endif
    char1_state = IDLE;
    char2_state = IDLE;
    hit1_lands  = 1'b0;
    hit2_lands  = 1'b0;
    cur_tag = "ko_before_rst";
    frame();
    frame();

    // Asynchronous reset in the middle of the KO hold
    rst = 1'b1;
    cur_tag = "rst_in_ko";
    e_h1 = 4'd3; e_h2 = 4'd3; e_s1 = 1'b0; e_s2 = 1'b0;
    e_ro = 1'b0; e_win = 2'b00; e_w1 = 4'd0; e_w2 = 4'd0;
    step(1'b0);
    rst = 1'b0;
    cur_tag = "post_rst";
    step(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hit_resolver.md
# hit_resolver

Sequential consumer of the per-player hit-landed levels produced by hit detection. Converts continuous overlap levels into one hit event per attack, applies damage and hitstun on game-frame ticks, arbitrates simultaneous hits, and runs round KO/restart sequencing. Sits between hit detection and the per-player character FSMs and HUD renderer.

## Interface
- MAX_HEALTH, 3: health loaded at reset and at each round start
- DAMAGE, 1: health removed per applied hit
- HEALTH_W, 4: health width; MAX_HEALTH must fit
- HITSTUN_FRAMES, 15: frame ticks of hitstun per applied hit (≥1)
- KO_HOLD_FRAMES, 120: frame ticks spent in KO before auto-restart (≥1)
- ATTACK_STATE, 3'b010: character FSM encoding of ATTACK
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-clk pulse per game frame
- hit1_lands  in  1  level: P1 hitbox overlaps P2
- hit2_lands  in  1  level: P2 hitbox overlaps P1
- char1_state  in  3  P1 FSM state
- char2_state  in  3  P2 FSM state
- p1_health, p2_health  out  HEALTH_W  current health
- p1_stun, p2_stun  out  1  level: player in hitstun
- p1_hit_pulse, p2_hit_pulse  out  1  one-clk: that player was damaged
- clash_pulse  out  1  one-clk: simultaneous hits cancelled
- round_over  out  1  high in KO state
- winner  out  2  01 P1, 10 P2, 11 double KO, 00 none
- p1_wins, p2_wins  out  4  rounds won, saturate at 15

## Operation
- States: FIGHT, KO. Reset → FIGHT.
- Per-attacker hit_used flag: set when that attacker's hit is consumed (applied or clashed); cleared on any clk where its charN_state != ATTACK_STATE. One hit per attack regardless of overlap duration.
- P1 hit valid: state==FIGHT, frame_tick, hit1_lands, !hit1_used, !p1_stun, !p2_stun. P2 symmetric.
- Applied hit on victim: health ← max(health − DAMAGE, 0); stun counter ← HITSTUN_FRAMES; victim hit pulse.
- Stun counter decrements on frame_tick when nonzero; load wins over decrement. pN_stun = counter≠0.
- KO: if either post-update health is 0, next state KO; winner set (both 0 → 11); non-zero-health player's wins counter +1 (none on double KO); KO counter ← KO_HOLD_FRAMES.
- In KO: all hits ignored; stun counters frozen; KO counter decrements per frame_tick; tick with counter==1 → FIGHT, healths ← MAX_HEALTH, stun counters, hit_used, winner cleared.
- Wins counters never reset except by rst.

## Timing
- Reset values: healths MAX_HEALTH, all other outputs 0, state FIGHT.
- Hits sampled on the clk edge with frame_tick=1; health, stun, pulses visible the following cycle (1-cycle latency).
- KO detection uses post-update health: round_over, winner, wins update on the same edge as the killing health update.
- Pulses are exactly one clk wide.
- hit levels between ticks are ignored; hit_used clearing is evaluated every clk.
- rst mid-round or mid-KO returns immediately to reset values including wins.

## Configuration
- SIMUL_HIT_TRADE_EN defined: P1 and P2 hits valid on the same tick both apply (trade); double KO possible; clash_pulse never asserts.
- Not defined: simultaneous valid hits both consumed (hit_used set), no damage, no stun, clash_pulse high one clk.

## Test plan
- rst then hit1_lands=1, char1_state=ATTACK for 10 ticks → p2_health 3→2 once, p2_hit_pulse one clk, p2_stun high exactly 15 ticks.
- Hold ATTACK after first hit, drop and re-raise ATTACK after stun → second hit applies, p2_health=1; no second hit without the ATTACK drop.
- P2 at health 1, P1 valid hit → p2_health=0, round_over=1, winner=01, p1_wins=1; after 120 ticks round_over=0, both health 3.
- Both valid hits same tick: with SIMUL_HIT_TRADE_EN both healths drop by 1; without, healths unchanged, clash_pulse one clk.
- Both at health 1, simultaneous hits with SIMUL_HIT_TRADE_EN → winner=11, neither wins counter increments.
- Assert rst during KO hold → state FIGHT, healths 3, wins 0, round_over 0 the cycle after assertion.
